// File: rtl/bcd_disp_pkg.sv
// Shared segment codes for the BCD display scanner.
// Segment order is {g,f,e,d,c,b,a}; all codes are active low (0 = lit).
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  // Non-decimal codes show a lone middle bar so corrupt digits stand out.
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder (active low).
// Ports:
//   i_bcd  in  4  BCD digit; codes A..F decode to a dash
//   o_seg  out 7  {g,f,e,d,c,b,a}, 0 = segment lit
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed common-anode 7-segment scanner for a packed BCD digit set.
// A load strobe captures new digits into a staging register; the staged set
// moves into the displayed (shadow) set only at a frame boundary, so a frame
// never mixes old and new digits.
// Ports:
//   clk         in   1             rising-edge clock
//   rst         in   1             asynchronous, active-high reset
//   digits_in   in   4*NUM_DIGITS  packed BCD, digit i = [4i+3:4i]
//   dp_in       in   NUM_DIGITS    decimal point per digit, 1 = lit
//   load        in   1             capture digits_in/dp_in into staging
//   blank_lz    in   1             1 = blank leading zeros (sampled live)
//   seg         out  7             {g,f,e,d,c,b,a}, active low
//   dp          out  1             decimal point, active low
//   an          out  NUM_DIGITS    anode enables, active low, one-hot-low
//   frame_done  out  1             pulse: new digit set now in shadow
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_staging;
  logic [NUM_DIGITS-1:0]   r_staging_dp;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_pending;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_boundary;
  logic [3:0]              w_digit;
  logic                    w_dp_sel;
  logic                    w_upper_zero;
  logic                    w_blank;
  logic [6:0]              w_seg_dec;
  logic [NUM_DIGITS-1:0]   w_an_next;

  assign w_tick     = (r_presc == PRE_MAX);
  assign w_boundary = w_tick && (r_idx == IDX_MAX);
  assign w_an_next  = ~(NUM_DIGITS'(1) << r_idx);

  // Select the current shadow digit and, walking down from the most
  // significant digit, note whether it and everything above it are zero.
  always_comb begin
    logic v_zero;
    w_digit      = 4'd0;
    w_dp_sel     = 1'b0;
    w_upper_zero = 1'b0;
    v_zero       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_zero = v_zero & (r_shadow[4*i +: 4] == 4'd0);
      if (r_idx == IDX_W'(i)) begin
        w_digit      = r_shadow[4*i +: 4];
        w_dp_sel     = r_shadow_dp[i];
        w_upper_zero = v_zero;
      end
    end
  end

  // Digit 0 always shows, so a value of zero still reads "0".
  assign w_blank = blank_lz && (r_idx != '0) && w_upper_zero;

  bcd_to_7seg u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_staging    <= '0;
      r_staging_dp <= '0;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + 1'b1;
      r_frame_done <= 1'b0;

      if (w_tick) begin
        r_an  <= w_an_next;
        r_seg <= w_blank ? SEG_OFF : w_seg_dec;
        r_dp  <= ~w_dp_sel;
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end

      // Boundary transfer takes the pre-edge staging contents.
      if (w_boundary && r_pending) begin
        r_shadow     <= r_staging;
        r_shadow_dp  <= r_staging_dp;
        r_pending    <= 1'b0;
        r_frame_done <= 1'b1;
      end

      // Placed last so a load on the boundary edge keeps pending set.
      if (load) begin
        r_staging    <= digits_in;
        r_staging_dp <= dp_in;
        r_pending    <= 1'b1;
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with NUM_DIGITS=4, REFRESH_DIV=4.
// The bench keeps its own prescaler phase (ph) and last-shown digit (di)
// to know when each refresh tick lands.
module tb_bcd_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int ph = 0;
  int di = 3;
  int fd_cnt = 0;

  bcd_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
    if (ph == 0) di = (di + 1) % 4;
  endtask

  task automatic next_tick();
    do cyc1(); while (ph != 0);
  endtask

  task automatic go_boundary();
    do next_tick(); while (di != 3);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    digits_in = d;
    dp_in = p;
    load = 1'b1;
    cyc1();
    load = 1'b0;
  endtask

  // Advance to the next tick, check the slot, then check it still holds
  // on the last cycle before the following tick.
  task automatic check_slot(input string tag, input logic [3:0] e_an,
                            input logic [6:0] e_seg, input logic e_dp, input logic e_fd);
    next_tick();
    chk({tag, ".an"}, 16'(an), 16'(e_an));
    chk({tag, ".seg"}, 16'(seg), 16'(e_seg));
    chk({tag, ".dp"}, 16'(dp), 16'(e_dp));
    chk({tag, ".fd"}, 16'(frame_done), 16'(e_fd));
    repeat (3) cyc1();
    chk({tag, ".an_hold"}, 16'(an), 16'(e_an));
    chk({tag, ".seg_hold"}, 16'(seg), 16'(e_seg));
  endtask

  initial begin
    // 1: reset, no load
    repeat (2) @(posedge clk);
    #1;
    chk("rst.an", 16'(an), 16'hF);
    chk("rst.seg", 16'(seg), 16'h7F);
    chk("rst.dp", 16'(dp), 16'h1);
    chk("rst.fd", 16'(frame_done), 16'h0);
    rst = 1'b0;
    ph = 0;
    di = 3;
    repeat (3) cyc1();
    chk("pre_tick.an", 16'(an), 16'hF);
    chk("pre_tick.seg", 16'(seg), 16'h7F);
    chk("pre_tick.dp", 16'(dp), 16'h1);
    check_slot("t1.d0", 4'hE, 7'h40, 1'b1, 1'b0);
    check_slot("t1.d1", 4'hD, 7'h40, 1'b1, 1'b0);
    check_slot("t1.d2", 4'hB, 7'h40, 1'b1, 1'b0);
    check_slot("t1.d3", 4'h7, 7'h40, 1'b1, 1'b0);
    chk("t1.fd_cnt", 16'(fd_cnt), 16'd0);

    // 2: load 1234
    do_load(16'h1234, 4'h0);
    go_boundary();
    chk("t2.fd_pulse", 16'(frame_done), 16'h1);
    cyc1();
    chk("t2.fd_low", 16'(frame_done), 16'h0);
    check_slot("t2.d0", 4'hE, 7'h19, 1'b1, 1'b0);
    check_slot("t2.d1", 4'hD, 7'h30, 1'b1, 1'b0);
    check_slot("t2.d2", 4'hB, 7'h24, 1'b1, 1'b0);
    check_slot("t2.d3", 4'h7, 7'h79, 1'b1, 1'b0);
    chk("t2.fd_cnt", 16'(fd_cnt), 16'd1);

    // 3: leading-zero blanking of 0070
    blank_lz = 1'b1;
    do_load(16'h0070, 4'h0);
    go_boundary();
    chk("t3.fd_pulse", 16'(frame_done), 16'h1);
    check_slot("t3.d0", 4'hE, 7'h40, 1'b1, 1'b0);
    check_slot("t3.d1", 4'hD, 7'h78, 1'b1, 1'b0);
    check_slot("t3.d2", 4'hB, 7'h7F, 1'b1, 1'b0);
    check_slot("t3.d3", 4'h7, 7'h7F, 1'b1, 1'b0);

    // 4: non-decimal code and decimal point
    blank_lz = 1'b0;
    do_load(16'h00A0, 4'b0010);
    go_boundary();
    chk("t4.fd_pulse", 16'(frame_done), 16'h1);
    check_slot("t4.d0", 4'hE, 7'h40, 1'b1, 1'b0);
    check_slot("t4.d1", 4'hD, 7'h3F, 1'b0, 1'b0);
    check_slot("t4.d2", 4'hB, 7'h40, 1'b1, 1'b0);
    check_slot("t4.d3", 4'h7, 7'h40, 1'b1, 1'b0);

    // 5: second load lands exactly on the boundary edge
    do_load(16'h1111, 4'h0);
    do cyc1(); while (!(ph == 3 && di == 2));
    do_load(16'h2222, 4'h0);
    chk("t5.boundary_di", 16'(di), 16'd3);
    chk("t5.fd_pulse1", 16'(frame_done), 16'h1);
    check_slot("t5.a0", 4'hE, 7'h79, 1'b1, 1'b0);
    check_slot("t5.a1", 4'hD, 7'h79, 1'b1, 1'b0);
    check_slot("t5.a2", 4'hB, 7'h79, 1'b1, 1'b0);
    check_slot("t5.a3", 4'h7, 7'h79, 1'b1, 1'b1);
    check_slot("t5.b0", 4'hE, 7'h24, 1'b1, 1'b0);
    check_slot("t5.b1", 4'hD, 7'h24, 1'b1, 1'b0);
    check_slot("t5.b2", 4'hB, 7'h24, 1'b1, 1'b0);
    check_slot("t5.b3", 4'h7, 7'h24, 1'b1, 1'b0);
    chk("t5.fd_cnt", 16'(fd_cnt), 16'd5);

    // 6: asynchronous reset mid-frame
    next_tick();
    cyc1();
    rst = 1'b1;
    #1;
    chk("t6.rst_an", 16'(an), 16'hF);
    chk("t6.rst_seg", 16'(seg), 16'h7F);
    chk("t6.rst_dp", 16'(dp), 16'h1);
    chk("t6.rst_fd", 16'(frame_done), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ph = 0;
    di = 3;
    repeat (3) cyc1();
    chk("t6.pre_tick_an", 16'(an), 16'hF);
    check_slot("t6.d0", 4'hE, 7'h40, 1'b1, 1'b0);
    check_slot("t6.d1", 4'hD, 7'h40, 1'b1, 1'b0);
    check_slot("t6.d2", 4'hB, 7'h40, 1'b1, 1'b0);
    check_slot("t6.d3", 4'h7, 7'h40, 1'b1, 1'b0);
    repeat (2) cyc1();
    chk("t6.fd_cnt", 16'(fd_cnt), 16'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
